// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream carrying a datapath and a control payload.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 24
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic elastic pipeline-stage register: DEPTH-entry FIFO of {data, ctrl}
// with valid/ready on both sides, synchronous flush and bubble counter.
module pipe_stage_buf #(
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          CTRL_W      = 24,
    parameter int unsigned          DEPTH       = 2,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    pipe_stage_buf_if.slave              in_if,
    pipe_stage_buf_if.master             out_if,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  bubble_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];

    ptr_t          wptr_q, wptr_d;
    ptr_t          rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   bub_q, bub_d;

    logic empty, full, pop, push;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = ~empty & out_if.ready;
    // A same-cycle pop frees the slot, so a full stage still accepts.
    assign in_if.ready = ~full | pop;
    assign push        = in_if.valid & in_if.ready & ~flush;

    assign out_if.valid = ~empty;
    assign out_if.data  = empty ? '0 : data_q[rptr_q];
    assign out_if.ctrl  = empty ? CTRL_BUBBLE : ctrl_q[rptr_q];
    assign count        = count_q;
    assign bubble_cnt   = bub_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        bub_d   = bub_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        if (out_if.ready && empty && bub_q != 16'hFFFF)
            bub_d = bub_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            bub_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            bub_q   <= bub_d;
        end
    end

    // Storage needs no reset: only slots below count are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_q[wptr_q] <= in_if.data;
            ctrl_q[wptr_q] <= in_if.ctrl;
        end
    end
endmodule
